// File: rtl/lights_pkg.sv
// Shared constants and state encoding for the host pattern-update command path.
package lights_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h77;
  localparam logic [7:0] RSP_OK    = 8'h6F;
  localparam logic [7:0] RSP_ERR   = 8'h3F;

  localparam int unsigned DATA_BYTES_DEF = 9;
  localparam int unsigned PATTERN_W      = 8 * DATA_BYTES_DEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_WRITE,
    ST_RESP
  } cmd_state_t;

endpackage

// File: rtl/cmd_timeout_ctr.sv
// Inter-byte timeout counter: counts enabled cycles since the last clear and
// flags the cycle in which LIMIT cycles will have elapsed at the next edge.
module cmd_timeout_ctr #(
  parameter int unsigned LIMIT = 2500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam int unsigned W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr || !en) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = en && !clr && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/pattern_cmd_ctrl.sv
// Host "w" [ADDR] [DATA_BYTES bytes] frame parser issuing one handshaked pattern
// write and an "o"/"?" response. Optional macro CMD_TIMEOUT_EN adds an inter-byte timeout.
module pattern_cmd_ctrl
  import lights_pkg::*;
#(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned DATA_BYTES     = DATA_BYTES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 2500000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic [7:0]              tx_data,
  output logic                    tx_start,
  input  logic                    tx_busy,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [8*DATA_BYTES-1:0] wr_data,
  output logic                    wr_en,
  input  logic                    wr_ready,
  output logic                    busy,
  output logic                    overrun,
  output logic                    timeout
);

  localparam int unsigned PW    = 8 * DATA_BYTES;
  localparam int unsigned CNT_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_BYTES - 1);

  cmd_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt;
  // Only the first DATA_BYTES-1 bytes need storing; the last one is taken straight from rx_data.
  logic [PW-9:0]    shift;
  logic             tmo_hit;

`ifdef CMD_TIMEOUT_EN
  logic tmo_en;
  assign tmo_en = (state_q == ST_ADDR) || (state_q == ST_DATA);

  cmd_timeout_ctr #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (tmo_en),
    .clr   (rx_valid),
    .expire(tmo_hit)
  );
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_en    = 1'b0;
    tx_start = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rx_valid) state_d = (rx_data == CMD_WRITE) ? ST_ADDR : ST_RESP;
      end
      ST_ADDR: begin
        if (rx_valid)     state_d = ST_DATA;
        else if (tmo_hit) state_d = ST_IDLE;
      end
      ST_DATA: begin
        if (rx_valid && cnt == LAST) state_d = ST_WRITE;
        else if (tmo_hit)            state_d = ST_IDLE;
      end
      ST_WRITE: begin
        wr_en = 1'b1;
        if (wr_ready) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      shift   <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      tx_data <= '0;
      overrun <= 1'b0;
      timeout <= 1'b0;
    end else begin
      timeout <= tmo_hit;
      unique case (state_q)
        ST_IDLE: begin
          if (rx_valid && rx_data != CMD_WRITE) tx_data <= RSP_ERR;
        end
        ST_ADDR: begin
          if (rx_valid) begin
            wr_addr <= ADDR_W'(rx_data);
            cnt     <= '0;
          end
        end
        ST_DATA: begin
          if (rx_valid) begin
            shift <= {shift[PW-17:0], rx_data};
            if (cnt == LAST) begin
              wr_data <= {shift, rx_data};
              cnt     <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_WRITE: begin
          if (rx_valid) overrun <= 1'b1;
          if (wr_ready) tx_data <= RSP_OK;
        end
        ST_RESP: begin
          if (rx_valid) overrun <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/pattern_cmd_ctrl.md
Name: pattern_cmd_ctrl

Overview:
- Sequences the host pattern-update protocol between the UART byte receiver/transmitter and the pattern memory.
- Parses a "w" [ADDR] [9 data bytes, MSB first] frame and issues one handshaked write of the 72-bit pattern word.
- Returns "o" (0x6F) on success and "?" (0x3F) on an unknown command byte.
- Sits inside the lights top level, between the uart rx/tx and the pattern RAM.

Parameters:
- ADDR_W, 8, pattern address width.
- DATA_BYTES, 9, payload bytes per frame; pattern word width = 8*DATA_BYTES.
- TIMEOUT_CYCLES, 2500000, inter-byte timeout in clk cycles; used only with CMD_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- rx_data  in  8  received byte; valid only when rx_valid=1.
- rx_valid  in  1  one-cycle strobe per received byte.
- tx_data  out  8  response byte; held stable from the tx_start cycle onward.
- tx_start  out  1  one-cycle request to the transmitter.
- tx_busy  in  1  transmitter is busy; tx_start must not be raised while this is high.
- wr_addr  out  ADDR_W  pattern write address.
- wr_data  out  8*DATA_BYTES  pattern write word, first-received byte in the MSBs.
- wr_en  out  1  write request, held until accepted.
- wr_ready  in  1  memory accepts the write in any cycle where wr_en=1 and wr_ready=1.
- busy  out  1  high in every state except IDLE.
- overrun  out  1  sticky flag: a byte arrived while it could not be accepted; cleared only by reset.
- timeout  out  1  one-cycle pulse when a frame is aborted by timeout; tied 0 without the macro.

Behaviour:
- Reset (rst_n=0 sampled on a clk edge):
  - state=IDLE; all outputs 0; byte counter and shift register cleared.
  - Any partial frame is discarded; reset takes priority over all other events.
- States: IDLE, ADDR, DATA, WRITE, RESP.
- IDLE:
  - rx_valid with rx_data=0x77 ("w") -> ADDR.
  - rx_valid with any other byte -> load resp=0x3F, go to RESP.
- ADDR:
  - rx_valid -> wr_addr <= rx_data; cnt <= 0; go to DATA.
- DATA:
  - On each rx_valid: shift <= {shift[8*DATA_BYTES-9:0], rx_data}; cnt++.
  - On the DATA_BYTES-th byte: wr_data is loaded with the complete word and state goes to WRITE.
- WRITE:
  - wr_en=1; wr_addr and wr_data held stable.
  - When wr_ready=1 in the same cycle: exactly one write is accepted; next cycle wr_en=0, resp=0x6F, go to RESP.
  - wr_ready high in an earlier cycle has no effect.
- RESP:
  - When tx_busy=0: tx_start=1 for one cycle with tx_data=resp, then go to IDLE.
  - Otherwise wait in RESP.
- Overrun: rx_valid in WRITE or RESP -> byte dropped; overrun <= 1; state unchanged.
- Latencies:
  - Last data byte strobe to wr_en=1: 1 cycle.
  - Write accept to tx_start: 1 cycle minimum.
- Simultaneous events: rx_valid on the same cycle as the write accept still counts as an overrun.
- Counter wrap: cnt never exceeds DATA_BYTES-1; it resets on entry to DATA.

Optional Feature:
- Macro: CMD_TIMEOUT_EN.
- Defined:
  - In ADDR or DATA, a counter increments each cycle and resets on rx_valid.
  - When it reaches TIMEOUT_CYCLES: timeout pulses once, the partial frame is discarded, state goes to IDLE, and no response is sent.
- Undefined: no counter; ADDR and DATA wait indefinitely; timeout=0.

Decomposition:
- Shared package lights_pkg holds:
  - CMD_WRITE=8'h77, RSP_OK=8'h6F, RSP_ERR=8'h3F.
  - State encoding constants.
  - PATTERN_W = 8*DATA_BYTES.
- Sub-module cmd_timeout_ctr (counter, clear, expire pulse), instantiated only under CMD_TIMEOUT_EN.
- The rest is a single FSM.

Test Plan:
- Normal frame:
  - Stimulus: bytes 0x77, 0xAA, 0x00..0x08; wr_ready=1.
  - Response: a single accepted write with wr_addr=0xAA and wr_data=72'h000102030405060708, then tx_start with tx_data=0x6F; busy returns to 0.
- Delayed write accept:
  - Stimulus: same frame, wr_ready held low 5 cycles after wr_en rises.
  - Response: wr_en stays high for 6 cycles with constant addr/data; exactly one accept.
- Unknown command:
  - Stimulus: byte 0x78 in IDLE.
  - Response: no wr_en; tx_start with 0x3F; back to IDLE.
- Reset mid-frame:
  - Stimulus: rst_n=0 for 1 cycle after 4 data bytes, then the full frame 0x77, 0x10, 0xFF x9.
  - Response: wr_addr=0x10, wr_data=72'hFFFFFFFFFFFFFFFFFF, no residue from the aborted frame.
- Transmitter busy and overrun:
  - Stimulus: tx_busy=1 for 20 cycles during RESP, plus an extra rx_valid during WRITE.
  - Response: tx_start only after tx_busy falls; overrun=1 and it stays 1 until reset.
- Timeout (with CMD_TIMEOUT_EN, TIMEOUT_CYCLES=100):
  - Stimulus: 0x77, 0xAA, then silence.
  - Response: timeout pulses 100 cycles after the last byte; IDLE; no tx_start.
